// File: rtl/smol_pkg.sv
// Shared types and constants for the smol fetch front end.
package smol_pkg;
  localparam int XLEN   = 32;
  localparam int ILEN   = 32;
  localparam int IBUF_W = XLEN + ILEN;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ALIGN_MASK;
  endfunction
endpackage

// File: rtl/smol_ibuf.sv
// Instruction buffer: synchronous FIFO of {pc, instr} with a single-cycle flush.
// The head entry is read straight from the storage registers (no read latency).
module smol_ibuf
  import smol_pkg::*;
#(
  parameter int WIDTH = IBUF_W,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Flush wins over push and pop; storage is not cleared, only the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/smol_fetch_seq.sv
// Fetch sequencer: issues one instruction-memory request at a time and queues
// {pc, instr} responses for the decoder, with redirect/flush support.
module smol_fetch_seq
  import smol_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              IBUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  output logic [ILEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready,
  output logic            busy,
  output fetch_state_t    dbg_state
);
  localparam int              CW         = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CW:0]     L_DEPTH    = (CW + 1)'(IBUF_DEPTH);
  localparam logic [XLEN-1:0] L_RESET_PC = word_align(RESET_PC);

  fetch_state_t       r_state;
  fetch_state_t       w_next_state;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_req_pc;
  logic               r_discard;
  logic               w_grant;
  logic               w_rsp;
  logic               w_push;
  logic               w_pop;
  logic [CW-1:0]      w_count;
  logic [CW:0]        w_count_after;
  logic               w_space_idle;
  logic               w_space_wait;
  logic [IBUF_W-1:0]  w_head;

  // Memory side: a request is accepted when imem_req & imem_gnt in the same cycle.
  // Decoder side: the head entry moves when dec_valid & dec_ready; redirect voids it.
  assign w_grant = (r_state == REQ) && imem_gnt;
  assign w_rsp   = (r_state == WAIT) && imem_rvalid;
  assign w_push  = w_rsp && !r_discard && !redirect;
  assign w_pop   = dec_valid && dec_ready && !redirect;

  assign w_count_after = {1'b0, w_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
  assign w_space_idle  = {1'b0, w_count} < L_DEPTH;
  assign w_space_wait  = w_count_after < L_DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // A redirect flushes the buffer, so a response arriving with it always finds room.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (fetch_en && w_space_idle) w_next_state = REQ;
      REQ:     if (imem_gnt) w_next_state = WAIT;
      WAIT:    if (w_rsp) w_next_state = (fetch_en && (redirect || w_space_wait)) ? REQ : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (r_state == REQ);
    busy     = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= L_RESET_PC;
      r_req_pc  <= L_RESET_PC;
      r_discard <= 1'b0;
    end else begin
      if (redirect)     r_pc <= word_align(redirect_pc);
      else if (w_grant) r_pc <= r_pc + PC_STEP;
      if (w_grant) r_req_pc <= r_pc;
      // A response arriving together with a redirect is itself the dropped one.
      if (w_rsp)
        r_discard <= 1'b0;
      else if (redirect && ((r_state == WAIT) || w_grant))
        r_discard <= 1'b1;
    end
  end

  smol_ibuf #(
    .WIDTH (IBUF_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({r_req_pc, imem_rdata}),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign imem_addr = r_pc;
  assign dec_valid = (w_count != '0);
  assign dec_pc    = w_head[IBUF_W-1:ILEN];
  assign dec_instr = w_head[ILEN-1:0];
  assign dbg_state = r_state;
endmodule

// File: tb/tb_smol_fetch_seq.sv
// Self-checking bench for smol_fetch_seq: vector table, directed corner cases,
// and a randomized run against a stream-level reference model.
module tb_smol_fetch_seq;
  import smol_pkg::*;

  localparam int DEPTH = 2;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;

  logic         imem_req, imem_req_2;
  logic [31:0]  imem_addr, imem_addr_2;
  logic         dec_valid, dec_valid_2;
  logic [31:0]  dec_instr, dec_instr_2;
  logic [31:0]  dec_pc, dec_pc_2;
  logic         busy, busy_2;
  fetch_state_t dbg_state, dbg_state_2;

  int n_checks = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];

  typedef struct packed {
    logic        fe, gnt, rv, rdy;
    logic        req;
    logic [31:0] addr, addr2;
    logic        valid;
    logic [31:0] pc;
    logic        busy;
  } vec_t;
  vec_t vec [12];

  always #5 clk = ~clk;

  smol_fetch_seq #(.RESET_PC(32'h0000_0000), .IBUF_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_ready(dec_ready), .busy(busy), .dbg_state(dbg_state)
  );

  smol_fetch_seq #(.RESET_PC(32'hFFFF_FFF8), .IBUF_DEPTH(DEPTH)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_req(imem_req_2), .imem_addr(imem_addr_2), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid_2), .dec_instr(dec_instr_2), .dec_pc(dec_pc_2),
    .dec_ready(dec_ready), .busy(busy_2), .dbg_state(dbg_state_2)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    ok = imem_req;
    chk1("req_timeout", ok, 1'b1);
  endtask

  // Grant the pending request, answer it one cycle later, return the address seen.
  task automatic mem_fetch(input logic [31:0] data, output logic [31:0] addr);
    bit ok;
    addr = 32'hFFFF_FFFF;
    wait_req(ok);
    if (ok) begin
      addr = imem_addr;
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = data; tick();
      imem_rvalid = 1'b0; imem_rdata = '0;
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference: the decoder must see exactly the non-stale responses, in order,
  // and every grant must carry the next sequential (or redirected) PC.
  task automatic run_random(input int ncycles);
    logic [31:0] exp_pc = '0;
    logic [31:0] out_addr = '0;
    logic [31:0] prev_addr = '0;
    bit out_v = 0, out_stale = 0, prev_hold = 0;
    bit rsp, grant, pop;
    int out_delay = 0, grants = 0, pops = 0;
    exp_q.delete();
    for (int c = 0; c < ncycles; c++) begin
      chk1("rnd_valid", dec_valid, exp_q.size() != 0);
      if (dec_valid && exp_q.size() != 0) begin
        chk32("rnd_dec_pc", dec_pc, exp_q[0][63:32]);
        chk32("rnd_dec_instr", dec_instr, exp_q[0][31:0]);
      end
      chk1("rnd_busy", busy, imem_req || out_v);
      chk32("rnd_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (prev_hold) begin
        chk1("rnd_hold_req", imem_req, 1'b1);
        chk32("rnd_hold_addr", imem_addr, prev_addr);
      end
      if (out_v) chk1("rnd_one_outstanding", imem_req, 1'b0);

      rsp = out_v && (out_delay == 0);
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      if (rsp) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(out_addr);
      end else if (!out_v && $urandom_range(0, 7) == 0) begin
        imem_rvalid = 1'b1;
      end
      grant = imem_req && !out_v && ($urandom_range(0, 2) != 0);
      imem_gnt = grant;
      redirect = ($urandom_range(0, 11) == 0);
      redirect_pc = $urandom;
      fetch_en = ($urandom_range(0, 7) != 0);
      dec_ready = 1'($urandom_range(0, 1));
      pop = dec_valid && dec_ready;

      if (grant) begin
        chk32("rnd_gnt_addr", imem_addr, exp_pc);
        grants++;
      end
      if (redirect) begin
        exp_q.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (pop && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          pops++;
        end
        if (rsp && !out_stale) begin
          chk1("rnd_no_overflow", exp_q.size() < DEPTH, 1'b1);
          exp_q.push_back({out_addr, mem_word(out_addr)});
        end
        if (grant) exp_pc = exp_pc + 32'd4;
      end

      if (rsp) begin
        out_v = 0;
        out_stale = 0;
      end else if (out_v) begin
        out_delay--;
      end
      if (redirect && out_v) out_stale = 1;
      if (grant) begin
        out_v = 1;
        out_addr = imem_addr;
        out_delay = $urandom_range(0, 2);
        out_stale = redirect;
      end
      prev_hold = imem_req && !grant && !redirect;
      prev_addr = imem_addr;
      tick();
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
    chk1("rnd_grant_activity", grants > 100, 1'b1);
    chk1("rnd_pop_activity", pops > 50, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    bit ok;

    //         fe gnt rv rdy req addr   addr(hi RESET_PC)  valid pc      busy
    vec[0]  = '{H, L, L, H, L, 32'h0, 32'hFFFF_FFF8, L, 32'h0, L};
    vec[1]  = '{H, L, L, H, H, 32'h0, 32'hFFFF_FFF8, L, 32'h0, H};
    vec[2]  = '{H, H, L, H, H, 32'h0, 32'hFFFF_FFF8, L, 32'h0, H};
    vec[3]  = '{H, L, H, H, L, 32'h4, 32'hFFFF_FFFC, L, 32'h0, H};
    vec[4]  = '{H, L, L, H, H, 32'h4, 32'hFFFF_FFFC, H, 32'h0, H};
    vec[5]  = '{H, H, L, H, H, 32'h4, 32'hFFFF_FFFC, L, 32'h0, H};
    vec[6]  = '{H, L, H, H, L, 32'h8, 32'h0000_0000, L, 32'h0, H};
    vec[7]  = '{H, L, L, H, H, 32'h8, 32'h0000_0000, H, 32'h4, H};
    vec[8]  = '{H, H, L, H, H, 32'h8, 32'h0000_0000, L, 32'h0, H};
    vec[9]  = '{H, L, H, H, L, 32'hC, 32'h0000_0004, L, 32'h0, H};
    vec[10] = '{L, L, L, H, H, 32'hC, 32'h0000_0004, H, 32'h8, H};
    vec[11] = '{L, L, L, H, H, 32'hC, 32'h0000_0004, L, 32'h0, H};

    // Reset values and the basic streaming sequence, both reset PCs in lock-step.
    do_reset();
    chk32("rst_dec_instr", dec_instr, 32'h0);
    chk32("rst_dec_pc", dec_pc, 32'h0);
    for (int k = 0; k < 12; k++) begin
      fetch_en = vec[k].fe;
      imem_gnt = vec[k].gnt;
      imem_rvalid = vec[k].rv;
      imem_rdata = vec[k].rv ? 32'h0000_0013 : 32'h0;
      dec_ready = vec[k].rdy;
      chk1($sformatf("tbl%0d_req", k), imem_req, vec[k].req);
      chk32($sformatf("tbl%0d_addr", k), imem_addr, vec[k].addr);
      chk32($sformatf("tbl%0d_addr_hi", k), imem_addr_2, vec[k].addr2);
      chk1($sformatf("tbl%0d_valid", k), dec_valid, vec[k].valid);
      chk1($sformatf("tbl%0d_busy", k), busy, vec[k].busy);
      if (vec[k].valid) begin
        chk32($sformatf("tbl%0d_pc", k), dec_pc, vec[k].pc);
        chk32($sformatf("tbl%0d_instr", k), dec_instr, 32'h0000_0013);
      end
      tick();
    end

    // Back-pressure: buffer fills to depth, fetching stops, then resumes at pc 8.
    do_reset();
    fetch_en = 1'b1; dec_ready = 1'b0;
    mem_fetch(32'hA000_0001, a); chk32("bp_addr0", a, 32'h0);
    mem_fetch(32'hA000_0002, a); chk32("bp_addr1", a, 32'h4);
    for (int i = 0; i < 6; i++) begin
      chk1("bp_no_req", imem_req, 1'b0);
      chk1("bp_not_busy", busy, 1'b0);
      chk1("bp_valid", dec_valid, 1'b1);
      tick();
    end
    chk32("bp_head_pc", dec_pc, 32'h0);
    chk32("bp_head_instr", dec_instr, 32'hA000_0001);
    dec_ready = 1'b1; tick();
    chk1("bp_second_valid", dec_valid, 1'b1);
    chk32("bp_second_pc", dec_pc, 32'h4);
    chk32("bp_second_instr", dec_instr, 32'hA000_0002);
    tick();
    chk1("bp_drained", dec_valid, 1'b0);
    dec_ready = 1'b0;
    mem_fetch(32'hA000_0003, a); chk32("bp_resume_addr", a, 32'h8);
    chk1("bp_resume_valid", dec_valid, 1'b1);
    chk32("bp_resume_pc", dec_pc, 32'h8);

    // Redirect while a response is in flight.
    do_reset();
    fetch_en = 1'b1; dec_ready = 1'b0;
    mem_fetch(32'hB000_0001, a);
    wait_req(ok); chk32("rw_addr", imem_addr, 32'h4);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    chk1("rw_pre_valid", dec_valid, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h0000_0101; tick(); redirect = 1'b0;
    chk1("rw_flushed", dec_valid, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 1'b0;
    chk1("rw_stale_dropped", dec_valid, 1'b0);
    mem_fetch(32'hB000_0002, a); chk32("rw_new_addr", a, 32'h0000_0100);
    chk1("rw_new_valid", dec_valid, 1'b1);
    chk32("rw_new_pc", dec_pc, 32'h0000_0100);
    chk32("rw_new_instr", dec_instr, 32'hB000_0002);

    // Redirect in REQ without grant, then redirect together with a grant.
    do_reset();
    fetch_en = 1'b1; dec_ready = 1'b1;
    wait_req(ok); chk32("rq_addr0", imem_addr, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0000_0306; tick(); redirect = 1'b0;
    chk1("rq_req_kept", imem_req, 1'b1);
    chk32("rq_new_addr", imem_addr, 32'h0000_0304);
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200; tick();
    imem_gnt = 1'b0; redirect = 1'b0;
    chk1("rg_waiting", imem_req, 1'b0);
    chk1("rg_busy", busy, 1'b1);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0304; tick(); imem_rvalid = 1'b0;
    chk1("rg_stale_dropped", dec_valid, 1'b0);
    mem_fetch(32'hC000_0001, a); chk32("rg_new_addr", a, 32'h0000_0200);
    chk1("rg_new_valid", dec_valid, 1'b1);
    chk32("rg_new_pc", dec_pc, 32'h0000_0200);
    chk32("rg_new_instr", dec_instr, 32'hC000_0001);

    do_reset();
    run_random(3000);

    // Asynchronous reset while waiting for a response.
    do_reset();
    fetch_en = 1'b1; dec_ready = 1'b0;
    mem_fetch(32'hD000_0001, a);
    wait_req(ok);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    chk1("ar_busy_before", busy, 1'b1);
    chk1("ar_valid_before", dec_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("ar_req", imem_req, 1'b0);
    chk32("ar_addr", imem_addr, 32'h0);
    chk32("ar_addr_hi", imem_addr_2, 32'hFFFF_FFF8);
    chk1("ar_valid", dec_valid, 1'b0);
    chk32("ar_instr", dec_instr, 32'h0);
    chk32("ar_pc", dec_pc, 32'h0);
    chk1("ar_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    wait_req(ok);
    chk32("ar_first_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/smol_fetch_seq.md
SMOL_FETCH_SEQ -- requirements
Module: smol_fetch_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset, word-aligned.
REQ-002 Parameter IBUF_DEPTH, default 2: instruction buffer entries, power of two, >= 2.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  clock; all state rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 fetch_en  in  1  permits issuing new fetches.
REQ-007 imem_req  out  1  instruction memory request.
REQ-008 imem_addr  out  32  fetch address; bits [1:0] always 0.
REQ-009 imem_gnt  in  1  request accepted this cycle.
REQ-010 imem_rvalid  in  1  response data valid.
REQ-011 imem_rdata  in  32  fetched instruction word.
REQ-012 redirect  in  1  branch/jump PC change, single-cycle pulse.
REQ-013 redirect_pc  in  32  new PC; bits [1:0] ignored, treated as 0.
REQ-014 dec_valid  out  1  buffer head valid toward decoder.
REQ-015 dec_instr  out  32  buffer-head instruction, feeds decoder instr input.
REQ-016 dec_pc  out  32  PC of dec_instr.
REQ-017 dec_ready  in  1  decoder consumes head when dec_valid & dec_ready.
REQ-018 busy  out  1  high when state != IDLE or a request is outstanding.

Function
REQ-019 FSM states IDLE, REQ, WAIT; at most one outstanding memory request.
REQ-020 IDLE -> REQ when fetch_en=1 and (count + 1) <= IBUF_DEPTH, reserving a slot.
REQ-021 REQ: imem_req=1, imem_addr=pc; on imem_gnt -> WAIT and pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-022 imem_req and imem_addr held stable in REQ until imem_gnt, except on redirect.
REQ-023 WAIT: on imem_rvalid, push {pc_of_request, imem_rdata} unless discard=1; next state REQ if fetch_en and space remains after the push, else IDLE.
REQ-024 imem_rvalid outside WAIT is ignored.
REQ-025 Space check counts the outstanding request as occupied; the buffer never overflows, even with simultaneous push and pop.
REQ-026 dec_valid = count != 0; dec_instr/dec_pc are the head entry, registered, zero latency from the buffer.
REQ-027 Pop on dec_valid & dec_ready; push and pop in the same cycle leave count unchanged.
REQ-028 Minimum latency: grant in cycle N, rvalid in N+1 -> dec_valid in N+2.
REQ-029 Redirect has top priority: buffer flushed, pc <= {redirect_pc[31:2],2'b00}, and a same-cycle pop is void.
REQ-030 Redirect in WAIT, or with imem_gnt in REQ: set discard; the next rvalid is dropped and clears discard.
REQ-031 Redirect in REQ without grant: next cycle imem_addr = new PC, state REQ.
REQ-032 fetch_en low: no new request; an outstanding request completes normally.
REQ-033 dec_pc increments by 4 per pushed entry, except after a redirect.

Reset
REQ-034 On rst_n low: state IDLE, pc=RESET_PC, count=0, discard=0, imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, busy=0.
REQ-035 Reset mid-transaction abandons the outstanding request; no rvalid is expected after release.

Structure
REQ-036 Shared package smol_pkg holds fetch_state_t (IDLE/REQ/WAIT), XLEN=32, ILEN=32, and the RESET_PC default constant.
REQ-037 Buffer is sub-module smol_ibuf: synchronous FIFO with flush, width 64 ({pc,instr}), depth IBUF_DEPTH.

Verification
REQ-038 Reset, fetch_en=1, gnt/rvalid each 1 cycle after request, rdata=32'h0000_0013 -> dec_pc 0,4,8 on consecutive entries, first dec_valid 2 cycles after first grant.
REQ-039 dec_ready=0, depth 2 -> exactly two entries (pc 0,4) buffered, imem_req then stays 0, busy=0; dec_ready=1 resumes fetching at pc 8.
REQ-040 Redirect to 32'h0000_0101 while in WAIT -> in-flight rvalid dropped, buffer empty, next imem_addr=32'h0000_0100, next dec_pc=32'h0000_0100.
REQ-041 Redirect in the same cycle as imem_gnt -> that response discarded; no stale instruction ever has dec_valid=1.
REQ-042 RESET_PC=32'hFFFF_FFF8 -> imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-043 rst_n asserted in WAIT -> all outputs at reset values asynchronously; after release the first imem_addr=RESET_PC.
